// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage sitting right after execute.
// Takes the LSU command, effective address, store data and destination
// register from execute. Runs one data-bus request/ack transaction per
// load or store. Formats big-endian load data and hands rd number/value
// to writeback. Stalls the pipeline while a bus transaction is outstanding.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   i_exec_stall, i_fetch_stall  stall requests from other stages
//   o_mem_stall               this stage is busy; freeze the pipeline
//   o_addr_error              misaligned access presented this cycle
//   i_rd_no, i_alu_result     destination reg / effective address or ALU value
//   i_lsu_op, i_lsu_lns, i_lsu_ext  size (0 idle,1 byte,2 half,3 word), load, sign-extend
//   i_mem_data                store data
//   o_dbus_*                  data-bus request: addr, req, wr, be, wdata
//   i_dbus_ack, i_dbus_rdata  bus completion and read data
//   o_rd_no, o_rd_val         writeback register number (0 = none) and value
module mem_access #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_exec_stall,
  input  logic                  i_fetch_stall,
  output logic                  o_mem_stall,
  output logic                  o_addr_error,
  input  logic [4:0]            i_rd_no,
  input  logic [ADDR_WIDTH-1:0] i_alu_result,
  input  logic [1:0]            i_lsu_op,
  input  logic                  i_lsu_lns,
  input  logic                  i_lsu_ext,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic [ADDR_WIDTH-1:0] o_dbus_addr,
  output logic                  o_dbus_req,
  output logic                  o_dbus_wr,
  output logic [3:0]            o_dbus_be,
  output logic [DATA_WIDTH-1:0] o_dbus_wdata,
  input  logic                  i_dbus_ack,
  input  logic [DATA_WIDTH-1:0] i_dbus_rdata,
  output logic [4:0]            o_rd_no,
  output logic [DATA_WIDTH-1:0] o_rd_val
);

  localparam logic [1:0] LSU_IDLE = 2'd0;
  localparam logic [1:0] LSU_BYTE = 2'd1;
  localparam logic [1:0] LSU_HALF = 2'd2;
  localparam logic [1:0] LSU_WORD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_r, state_nxt_s;
  logic            oth_s, misaligned_s, mem_op_s, start_s, wb_en_s;
  logic [3:0]      be_s;
  logic [31:0]     wdata_s, load_val_s;
  logic [31:0]     lbuf_r;
  logic [1:0]      op_r, off_r;
  logic            ext_r;

  assign oth_s        = i_exec_stall | i_fetch_stall;
  assign mem_op_s     = (i_lsu_op != LSU_IDLE) & ~misaligned_s;
  assign start_s      = (state_r == ST_IDLE) & mem_op_s & ~oth_s;
  assign o_addr_error = misaligned_s;
  // DONE is deliberately non-stalling so writeback can advance out of it.
  assign o_mem_stall  = ((state_r == ST_IDLE) & mem_op_s) | (state_r == ST_REQ);
  assign wb_en_s      = ~(oth_s | o_mem_stall);

  // Alignment check, big-endian byte enables and store-data replication.
  always_comb begin
    misaligned_s = 1'b0;
    be_s         = 4'b0000;
    wdata_s      = 32'd0;
    case (i_lsu_op)
      LSU_BYTE: begin
        be_s    = 4'b1000 >> i_alu_result[1:0];
        wdata_s = {4{i_mem_data[7:0]}};
      end
      LSU_HALF: begin
        misaligned_s = i_alu_result[0];
        be_s         = i_alu_result[1] ? 4'b0011 : 4'b1100;
        wdata_s      = {2{i_mem_data[15:0]}};
      end
      LSU_WORD: begin
        misaligned_s = (i_alu_result[1:0] != 2'b00);
        be_s         = 4'b1111;
        wdata_s      = i_mem_data;
      end
      default: begin
        misaligned_s = 1'b0;
      end
    endcase
  end

  // Next-state logic of the bus transaction FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_nxt_s = ST_REQ;
        else         state_nxt_s = ST_IDLE;
      end
      ST_REQ: begin
        if (i_dbus_ack) state_nxt_s = ST_DONE;
        else            state_nxt_s = ST_REQ;
      end
      ST_DONE: begin
        if (!oth_s) state_nxt_s = ST_IDLE;
        else        state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Bus request registers: captured on start, held stable until ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_dbus_req   <= 1'b0;
      o_dbus_wr    <= 1'b0;
      o_dbus_addr  <= '0;
      o_dbus_be    <= 4'b0000;
      o_dbus_wdata <= '0;
      op_r         <= LSU_IDLE;
      off_r        <= 2'b00;
      ext_r        <= 1'b0;
    end else if (start_s) begin
      o_dbus_req   <= 1'b1;
      o_dbus_wr    <= ~i_lsu_lns;
      o_dbus_addr  <= {i_alu_result[ADDR_WIDTH-1:2], 2'b00};
      o_dbus_be    <= be_s;
      o_dbus_wdata <= wdata_s;
      op_r         <= i_lsu_op;
      off_r        <= i_alu_result[1:0];
      ext_r        <= i_lsu_ext;
    end else if ((state_r == ST_REQ) && i_dbus_ack) begin
      o_dbus_req   <= 1'b0;
    end else begin
      o_dbus_req   <= o_dbus_req;
    end
  end

  // Load buffer captures read data at the completing ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      lbuf_r <= 32'd0;
    else if ((state_r == ST_REQ) && i_dbus_ack)   lbuf_r <= i_dbus_rdata;
    else                                          lbuf_r <= lbuf_r;
  end

  // Select the addressed byte/half of the buffer and extend it.
  always_comb begin
    load_val_s = lbuf_r;
    case (op_r)
      LSU_BYTE: begin
        logic [7:0] b;
        case (off_r)
          2'd0:    b = lbuf_r[31:24];
          2'd1:    b = lbuf_r[23:16];
          2'd2:    b = lbuf_r[15:8];
          default: b = lbuf_r[7:0];
        endcase
        load_val_s = {{24{ext_r & b[7]}}, b};
      end
      LSU_HALF: begin
        logic [15:0] h;
        if (off_r[1]) h = lbuf_r[15:0];
        else          h = lbuf_r[31:16];
        load_val_s = {{16{ext_r & h[15]}}, h};
      end
      default: load_val_s = lbuf_r;
    endcase
  end

  // Writeback registers advance whenever the pipeline is not frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rd_no  <= 5'd0;
      o_rd_val <= '0;
    end else if (wb_en_s) begin
      if (((i_lsu_op != LSU_IDLE) && !i_lsu_lns) || misaligned_s) o_rd_no <= 5'd0;
      else                                                      o_rd_no <= i_rd_no;
      if ((i_lsu_op != LSU_IDLE) && i_lsu_lns) o_rd_val <= load_val_s;
      else                                     o_rd_val <= i_alu_result;
    end else begin
      o_rd_no  <= o_rd_no;
      o_rd_val <= o_rd_val;
    end
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access pipeline stage directly downstream of execute.
- Consumes execute's LSU command (op, load/store, sign-extend), effective address (ALU result), store data and destination register number.
- Drives the data-bus request/acknowledge handshake, formats load data, and presents rd number/value to writeback.
- Asserts a memory stall to the control unit while a bus transaction is outstanding.

Parameters:
- ADDR_WIDTH, 32, address width (must be 32).
- DATA_WIDTH, 32, data/register width (must be 32).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- i_exec_stall  in  1  stall from other sources.
- i_fetch_stall  in  1  stall from other sources.
- o_mem_stall  out  1  stage busy; freezes pipeline.
- o_addr_error  out  1  misaligned access this cycle.
- i_rd_no  in  5  destination register from execute.
- i_alu_result  in  32  effective address or ALU value.
- i_lsu_op  in  2  0=IDLE, 1=BYTE, 2=HALF, 3=WORD.
- i_lsu_lns  in  1  1=load, 0=store.
- i_lsu_ext  in  1  1=sign-extend load, 0=zero-extend.
- i_mem_data  in  32  store data (rt).
- o_dbus_addr  out  32  word-aligned bus address.
- o_dbus_req  out  1  request valid.
- o_dbus_wr  out  1  1=write.
- o_dbus_be  out  4  byte enables; bit3 = bits 31:24.
- o_dbus_wdata  out  32  write data.
- i_dbus_ack  in  1  transaction complete.
- i_dbus_rdata  in  32  read data, valid with ack.
- o_rd_no  out  5  writeback register; 0 = no write.
- o_rd_val  out  32  writeback value.

Behaviour:
- Reset (async, rst=1):
  - Outputs: o_dbus_req=0, o_dbus_wr=0, o_dbus_addr=0, o_dbus_be=0, o_dbus_wdata=0, o_rd_no=0, o_rd_val=0.
  - FSM=IDLE; an in-flight request is abandoned immediately.
- Byte ordering:
  - Big-endian: addr[1:0]=0 selects bits 31:24.
  - Half at addr[1]=0 selects bits 31:16.
- Alignment:
  - HALF with addr[0]=1, or WORD with addr[1:0]!=0, is misaligned.
  - o_addr_error is asserted combinationally for every cycle such an op is presented.
  - No bus request is issued; the op is treated as non-stalling; o_rd_no is written 0.
- Other stall: oth = i_exec_stall | i_fetch_stall.
- FSM IDLE:
  - If op!=IDLE, aligned and !oth: capture bus outputs and go to REQ.
  - Captured values: addr={addr[31:2],2'b00}, wr=!lns, be per size/offset, wdata.
  - wdata replication: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
  - Read be is the same as write be.
- FSM REQ:
  - o_dbus_req=1; all bus outputs held stable until ack.
  - On ack: latch i_dbus_rdata into a load buffer and go to DONE.
  - Ack in the first REQ cycle is legal.
- FSM DONE:
  - Bus idle. If !oth, go to IDLE; otherwise stay in DONE.
  - The inputs still describe the completed op and must not reissue it.
- o_mem_stall = (IDLE & op!=IDLE & aligned) | REQ. Deasserted in DONE.
- Writeback registers update when !(oth | o_mem_stall):
  - o_rd_no <= (store | misaligned) ? 0 : i_rd_no.
  - o_rd_val <= load ? formatted buffer : i_alu_result.
- Load formatting:
  - Select byte/half by the captured addr[1:0].
  - Extend to 32 bits: sign if ext=1, else zero.
- Minimum load/store latency: 2 stall cycles (detect, REQ with same-cycle ack), then the DONE advance.
- Ack in IDLE or DONE is ignored.
- i_dbus_rdata is ignored for writes.

Test Plan:
- Aligned LW at 0x100, rd=5, ack after 3 REQ cycles, rdata=0x89ABCDEF:
  - Required: req held 3 cycles with addr 0x100, be=4'b1111, wr=0.
  - Required: o_mem_stall deasserts in DONE; then o_rd_no=5, o_rd_val=0x89ABCDEF.
- LB at 0x203, ext=1, rdata=0x000000F0:
  - Required: be=4'b0001, o_rd_val=0xFFFFFFF0.
  - Same with ext=0 -> o_rd_val=0x000000F0.
- SH at 0x302, data=0x1234ABCD:
  - Required: addr 0x300, be=4'b0011, wdata=0xABCDABCD, wr=1, o_rd_no=0.
- LW at 0x101:
  - Required: o_addr_error=1, no req, no o_mem_stall, o_rd_no=0.
- ALU op (op=IDLE), rd=7, result=0x55:
  - Required: o_rd_no=7, o_rd_val=0x55 the next edge, no stall.
  - Repeat with i_exec_stall held across DONE: no second request issued.
- Assert rst while in REQ:
  - Required: o_dbus_req drops without a clock edge; FSM IDLE; all outputs 0.
